hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_load_use_detect.sv | 24 ++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: divide FSM state
// encodings, parameter defaults and a helper for the timeout counter width.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_START = 2'd1,
    DIV_BUSY  = 2'd2
  } state_t;

  localparam int unsigned DIV_TIMEOUT_DEF = 32'd64;
  localparam int unsigned CNT_W_DEF       = 32'd32;

  // Width needed to hold 0 .. n-1, never less than one bit.
  function automatic int unsigned tmo_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Purely combinational load-use compare: a load in EX whose destination
// (other than x0) is read by the instruction currently in ID.
module load_use_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       hazard
);

  // Compare both ID source operands against the load destination.
  always_comb begin
    hazard = 1'b0;
    if (ex_mem_read && (ex_rd != 5'd0)) begin
      hazard = (id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd));
    end else begin
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle divide stall FSM with timeout,
// branch/jump redirect flush and load-use interlock, plus a saturating
// stall-cycle performance counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ex_is_div,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_redirect,
  input  logic             div_done,
  output logic             div_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             div_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned TMO_W = tmo_width(DIV_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic               div_err_q, div_err_d;
  logic               div_start_q, div_start_d;
  logic               lu_hazard;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .hazard      (lu_hazard)
  );

  // Next-state and stage-control decode; divide FSM outranks redirect,
  // which outranks the load-use interlock.
  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    div_err_d     = div_err_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_is_div) begin
          state_d       = DIV_START;
          tmo_cnt_d     = '0;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
        end else if (ex_redirect) begin
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
        end else if (lu_hazard) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_flush   = 1'b1;
        end else begin
          state_d       = RUN;
        end
      end
      DIV_START: begin
        state_d       = DIV_BUSY;
        tmo_cnt_d     = '0;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
      end
      DIV_BUSY: begin
        if (div_done) begin
          // Result lands in EX/MEM this cycle; done beats the terminal count.
          state_d       = RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Give up: let the pipe move on but drop the divide instruction.
          state_d       = RUN;
          ex_mem_bubble = 1'b1;
          div_err_d     = 1'b1;
        end else begin
          tmo_cnt_d     = tmo_cnt_q + TMO_W'(1);
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
        end
      end
      default: begin
        state_d       = RUN;
        tmo_cnt_d     = '0;
      end
    endcase
  end

  // Saturating stall counter and Moore divide-launch pulse.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    div_start_d = (state_d == DIV_START);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= RUN;
      tmo_cnt_q      <= '0;
      stall_cycles_q <= '0;
      div_err_q      <= 1'b0;
      div_start_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      div_err_q      <= div_err_d;
      div_start_q    <= div_start_d;
    end
  end

  assign div_start       = div_start_q;
  assign div_timeout_err = div_err_q;
  assign stall_cycles    = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (DIV_TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ex_is_div, ex_mem_read, id_use_rs1, id_use_rs2, ex_redirect, div_done;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       div_start, pc_write, if_id_write, id_ex_write;
  logic       if_id_flush, id_ex_flush, ex_mem_bubble, div_timeout_err;
  logic [3:0] stall_cycles;
  logic [5:0] ctl;

  int n_asrt = 0;
  int n_fail = 0;

  // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble}
  localparam logic [5:0] NORMAL   = 6'b111_00_0;
  localparam logic [5:0] DIVSTALL = 6'b000_00_1;
  localparam logic [5:0] TMO      = 6'b111_00_1;
  localparam logic [5:0] REDIR    = 6'b111_11_0;
  localparam logic [5:0] LOADUSE  = 6'b001_01_0;

  hazard_ctrl #(.DIV_TIMEOUT(4), .CNT_W(4)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .ex_is_div       (ex_is_div),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_redirect     (ex_redirect),
    .div_done        (div_done),
    .div_start       (div_start),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_bubble   (ex_mem_bubble),
    .div_timeout_err (div_timeout_err),
    .stall_cycles    (stall_cycles)
  );

  assign ctl = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble};

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic div, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic redir, input logic done);
    ex_is_div = div; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    ex_redirect = redir; div_done = done;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    idle();
    repeat (2) next_cycle();
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_err", 32'(div_timeout_err), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'(NORMAL));
    drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("rst_ctl_loaduse", 32'(ctl), 32'(LOADUSE));
    next_cycle();
    chk("rst_stall_hold", 32'(stall_cycles), 32'd0);
    RESET = 1'b0;
    idle();

    // Load-use on rs2
    drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("lu_rs2_ctl", 32'(ctl), 32'(LOADUSE));
    next_cycle();
    idle();
    chk("lu_rs2_stall", 32'(stall_cycles), 32'd1);
    chk("lu_rs2_after", 32'(ctl), 32'(NORMAL));

    // Load-use on rs1
    drive(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("lu_rs1_ctl", 32'(ctl), 32'(LOADUSE));
    next_cycle();
    idle();
    chk("lu_rs1_stall", 32'(stall_cycles), 32'd2);

    // Non-hazards
    drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lu_x0", 32'(ctl), 32'(NORMAL));
    drive(1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("lu_unused_src", 32'(ctl), 32'(NORMAL));
    drive(1'b0, 1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("lu_not_load", 32'(ctl), 32'(NORMAL));
    next_cycle();
    chk("nohaz_stall", 32'(stall_cycles), 32'd2);

    // Redirect beats load-use
    drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("redir_ctl", 32'(ctl), 32'(REDIR));
    next_cycle();
    idle();
    chk("redir_stall", 32'(stall_cycles), 32'd2);

    // Divide, done at N+5 (coincides with terminal count: done wins)
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("div_n_ctl", 32'(ctl), 32'(DIVSTALL));
    chk("div_n_start", 32'(div_start), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("div_n1_start", 32'(div_start), 32'd1);
    chk("div_n1_ctl", 32'(ctl), 32'(DIVSTALL));
    next_cycle();
    idle();
    chk("div_n2_start", 32'(div_start), 32'd0);
    chk("div_n2_ctl", 32'(ctl), 32'(DIVSTALL));
    next_cycle();
    chk("div_n3_ctl", 32'(ctl), 32'(DIVSTALL));
    next_cycle();
    chk("div_n4_ctl", 32'(ctl), 32'(DIVSTALL));
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("div_n5_done_ctl", 32'(ctl), 32'(NORMAL));
    next_cycle();
    idle();
    chk("div_stall", 32'(stall_cycles), 32'd7);
    chk("div_done_wins_err", 32'(div_timeout_err), 32'd0);
    chk("div_back_run", 32'(ctl), 32'(NORMAL));

    // Divide with early done
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("early_done_ctl", 32'(ctl), 32'(NORMAL));
    next_cycle();
    idle();
    chk("early_done_stall", 32'(stall_cycles), 32'd9);

    // Divide timeout: four DIV_BUSY cycles, last one drops the instruction
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    next_cycle();
    chk("tmo_busy0", 32'(ctl), 32'(DIVSTALL));
    next_cycle();
    next_cycle();
    chk("tmo_busy2", 32'(ctl), 32'(DIVSTALL));
    next_cycle();
    chk("tmo_term_ctl", 32'(ctl), 32'(TMO));
    chk("tmo_err_pre", 32'(div_timeout_err), 32'd0);
    next_cycle();
    chk("tmo_err", 32'(div_timeout_err), 32'd1);
    chk("tmo_stall", 32'(stall_cycles), 32'd14);
    chk("tmo_run", 32'(ctl), 32'(NORMAL));
    next_cycle();
    chk("tmo_err_sticky", 32'(div_timeout_err), 32'd1);

    // Reset during DIV_START
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    chk("rs_start_pre", 32'(div_start), 32'd1);
    RESET = 1'b1;
    #1;
    chk("rs_start_div_start", 32'(div_start), 32'd0);
    chk("rs_start_stall", 32'(stall_cycles), 32'd0);
    chk("rs_start_err", 32'(div_timeout_err), 32'd0);
    next_cycle();
    RESET = 1'b0;
    #1;
    next_cycle();
    chk("rs_start_post_ds", 32'(div_start), 32'd0);
    chk("rs_start_post_ctl", 32'(ctl), 32'(NORMAL));
    next_cycle();
    chk("rs_start_post_ds2", 32'(div_start), 32'd0);

    // Reset mid-DIV_BUSY
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
    chk("rb_busy_ctl", 32'(ctl), 32'(DIVSTALL));
    chk("rb_busy_stall", 32'(stall_cycles), 32'd3);
    RESET = 1'b1;
    #1;
    chk("rb_ctl", 32'(ctl), 32'(NORMAL));
    chk("rb_stall", 32'(stall_cycles), 32'd0);
    chk("rb_div_start", 32'(div_start), 32'd0);
    next_cycle();
    RESET = 1'b0;
    #1;
    next_cycle();
    chk("rb_post_ctl", 32'(ctl), 32'(NORMAL));
    chk("rb_post_ds", 32'(div_start), 32'd0);

    // Held divide: counter saturates at 15
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (24) next_cycle();
    chk("sat_stall", 32'(stall_cycles), 32'd15);
    chk("sat_err", 32'(div_timeout_err), 32'd1);
    repeat (3) next_cycle();
    chk("sat_hold", 32'(stall_cycles), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
